ghost_mode_ctrl: RTL
====================

Name: ghost_mode_ctrl

Overview:
- Per-ghost direction scheduler. Drives the 8-bit direction command consumed by a ghost motion block (same encoding as the keyboard path: 8'h04 left, 8'h07 right, 8'h16 down, 8'h1A up, 8'h00 hold).
- Sequences the ghost through SCATTER / CHASE / FRIGHT modes on a seconds timer.
- Picks each move from the wall flags and a target point: a corner, Pac-Man's position, or a pseudo-random choice.

Parameters:
- SCATTER_SECS, 7, seconds per SCATTER phase
- CHASE_SECS, 20, seconds per CHASE phase
- FRIGHT_SECS, 6, seconds of FRIGHT after a power pellet
- SCATTER_ROUNDS, 4, SCATTER phases before permanent CHASE
- DECIDE_FRAMES, 8, frames between forced re-decisions
- SCAT_X, 390, scatter target X
- SCAT_Y, 7, scatter target Y
- LFSR_SEED, 16'hACE1, nonzero LFSR reset seed

Ports:
- frame_clk  in  1  frame clock; all logic on rising edge
- Reset  in  1  async active-high reset
- restart  in  1  sync level; life lost or new level, same effect as Reset
- sec  in  1  one-second tick; counted on its 0->1 transition as sampled by frame_clk
- pellet  in  1  power pellet eaten; sync pulse, one frame
- ghostX, ghostY  in  10 each  current ghost centre
- pacX, pacY  in  10 each  current Pac-Man centre
- mapL, mapR, mapB, mapT  in  5 each  wall flags; 0 = open in that direction
- dircode  out  8  direction command to the ghost motion block
- mode  out  2  0 = SCATTER, 1 = CHASE, 2 = FRIGHT
- fright  out  1  high in FRIGHT; selects the blue sprite

Behaviour:
- Reset and restart values:
  - dircode = 8'h00, mode = SCATTER, fright = 0
  - sec counter = 0, round counter = 0, decide counter = 0
  - saved mode = SCATTER, saved sec count = 0, LFSR = LFSR_SEED
- Priority: Reset > restart > pellet > sec tick.
- Mode FSM (sec count cleared on every transition):
  - SCATTER -> CHASE when the count reaches SCATTER_SECS. Round counter increments.
  - CHASE -> SCATTER when the count reaches CHASE_SECS, only if round < SCATTER_ROUNDS. Otherwise CHASE holds forever and the count saturates.
- FRIGHT entry on pellet from SCATTER or CHASE:
  - Save the current mode and its sec count; go to FRIGHT with count 0.
- Pellet while already in FRIGHT:
  - Restart the FRIGHT count to 0; the saved mode is unchanged.
- FRIGHT exit when the count reaches FRIGHT_SECS:
  - Restore the saved mode and saved count.
- Same-frame collision: pellet and sec tick together apply the pellet; that tick is dropped.
- Decision event, any of:
  - decide counter wraps at DECIDE_FRAMES-1
  - current dircode direction has a nonzero wall flag
  - dircode = 8'h00
  - mode changed on the previous edge
- Between decisions dircode holds. dircode is registered: a decision uses inputs sampled on edge N and appears after edge N (1-frame latency).
- Forced reversal: on the first decision after any mode transition, choose the opposite of the current dircode if that side is open; otherwise use the normal rule.
- Target: SCATTER uses (SCAT_X, SCAT_Y); CHASE uses (pacX, pacY).
- Normal rule (SCATTER/CHASE):
  - dx = target - ghost, signed 11-bit, same for dy.
  - Primary axis is X if |dx| > |dy|, else Y (tie -> Y).
  - "Toward" with a zero delta means left or up.
  - Candidate order: primary-toward, secondary-toward, secondary-away, primary-away.
  - Pick the first candidate that is open and is not the reverse of the current dircode.
  - If none qualifies, take the reverse if it is open; otherwise output 8'h00.
- FRIGHT rule:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every frame.
  - LFSR[1:0] picks the start index into the order L, R, D, U.
  - Scan forward cyclically from that index with the same open/non-reverse and fallback rules.
- Wrap tunnel: the ghost X position jumping does not reset counters. Decisions proceed normally.
- Reset mid-FRIGHT: all state returns to the reset values; no saved mode survives.

Optional Feature:
- GHOST_FRIGHT_BLINK_EN adds output fright_blink (1 bit).
- With the macro defined:
  - In FRIGHT, when the count >= FRIGHT_SECS-2, fright_blink toggles every 8 frames; 0 otherwise.
  - Reset value 0.
- Without it: the port and logic are absent; fright is a steady level.

Test Plan:
- Reset, ghost at (142,166), all map flags 0, pac at (300,166) -> dircode 8'h00 after Reset. First decision gives 8'h07 toward scatter target (|dx|=248 > |dy|=159). mode = 0.
- Seven sec pulses -> mode becomes 1. dircode on the next decision is 8'h04, the reverse, since left is open. Then 8'h07 toward pac.
- Pellet at CHASE count 5 -> fright = 1, mode = 2. After 6 sec pulses, mode = 1, and the next CHASE exit occurs after 15 more pulses.
- Pellet and sec asserted in the same frame, then 6 more pulses -> FRIGHT ends on the 6th; the coincident tick is not counted.
- mapL = mapT = mapB = 1, current dircode 8'h04 -> dircode becomes 8'h07, the reverse fallback. All four flags nonzero -> dircode 8'h00.
- Complete 4 SCATTER rounds, then run 100 sec pulses -> mode stays 1. restart returns mode 0, dircode 8'h00, round 0.

Source files
------------

// File: rtl/ghost_mode_ctrl.sv
// ghost_mode_ctrl: per-ghost direction scheduler.
//
// Sequences a ghost through SCATTER / CHASE / FRIGHT on a one-second tick and
// picks a move from the wall flags and a target point. SCATTER aims at a fixed
// corner, CHASE aims at Pac-Man, and FRIGHT scans directions from an LFSR start.
// The direction codes match the keyboard path:
// 8'h04 left, 8'h07 right, 8'h16 down, 8'h1A up, 8'h00 hold.
//
// Ports:
//   frame_clk      frame clock; all state changes on its rising edge
//   Reset          asynchronous active-high reset
//   restart        synchronous level (life lost or new level); same effect as Reset
//   sec            one-second tick; counted on its 0->1 transition
//   pellet         one-frame pulse for a power pellet
//   ghostX/ghostY  ghost centre
//   pacX/pacY      Pac-Man centre
//   mapL/R/B/T     wall flags; 0 means open in that direction
//   dircode        registered direction command to the motion block
//   mode           0 SCATTER, 1 CHASE, 2 FRIGHT
//   fright         high in FRIGHT; selects the blue sprite
//   fright_blink   (GHOST_FRIGHT_BLINK_EN only) toggles every 8 frames near FRIGHT end
//
// Optional feature macro: GHOST_FRIGHT_BLINK_EN adds the fright_blink output.
module ghost_mode_ctrl #(
  parameter int unsigned SCATTER_SECS   = 7,
  parameter int unsigned CHASE_SECS     = 20,
  parameter int unsigned FRIGHT_SECS    = 6,
  parameter int unsigned SCATTER_ROUNDS = 4,
  parameter int unsigned DECIDE_FRAMES  = 8,
  parameter int unsigned SCAT_X         = 390,
  parameter int unsigned SCAT_Y         = 7,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       restart,
  input  logic       sec,
  input  logic       pellet,
  input  logic [9:0] ghostX,
  input  logic [9:0] ghostY,
  input  logic [9:0] pacX,
  input  logic [9:0] pacY,
  input  logic [4:0] mapL,
  input  logic [4:0] mapR,
  input  logic [4:0] mapB,
  input  logic [4:0] mapT,
  output logic [7:0] dircode,
  output logic [1:0] mode,
`ifdef GHOST_FRIGHT_BLINK_EN
  output logic       fright_blink,
`endif
  output logic       fright
);

  typedef enum logic [1:0] {
    ModeScatter = 2'd0,
    ModeChase   = 2'd1,
    ModeFright  = 2'd2
  } mode_e;

  localparam int unsigned CntW = 8;
  localparam logic [CntW-1:0] ScatterLim = CntW'(SCATTER_SECS);
  localparam logic [CntW-1:0] ChaseLim   = CntW'(CHASE_SECS);
  localparam logic [CntW-1:0] FrightLim  = CntW'(FRIGHT_SECS);
  localparam logic [CntW-1:0] RoundLim   = CntW'(SCATTER_ROUNDS);
  localparam logic [CntW-1:0] DecideLim  = CntW'(DECIDE_FRAMES - 1);
  localparam logic [9:0]      ScatX      = 10'(SCAT_X);
  localparam logic [9:0]      ScatY      = 10'(SCAT_Y);

  // Direction indices; reversing a direction is idx ^ 1.
  localparam logic [1:0] DirL = 2'd0;
  localparam logic [1:0] DirR = 2'd1;
  localparam logic [1:0] DirD = 2'd2;
  localparam logic [1:0] DirU = 2'd3;

  function automatic logic [7:0] dir_code(input logic [1:0] idx);
    logic [7:0] code;
    unique case (idx)
      DirL:    code = 8'h04;
      DirR:    code = 8'h07;
      DirD:    code = 8'h16;
      default: code = 8'h1A;
    endcase
    return code;
  endfunction

  mode_e          mode_q, mode_d, saved_mode_q, saved_mode_d;
  logic [CntW-1:0] sec_cnt_q, sec_cnt_d, saved_cnt_q, saved_cnt_d;
  logic [CntW-1:0] round_q, round_d, decide_cnt_q, decide_cnt_d, cnt_inc;
  logic [15:0]    lfsr_q, lfsr_d;
  logic [7:0]     dircode_q, dircode_d;
  logic           sec_prev_q, mode_chg_q, fright_q, sec_tick;

  assign sec_tick = sec & ~sec_prev_q;
  assign cnt_inc  = sec_cnt_q + 8'd1;
  assign lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign decide_cnt_d = (decide_cnt_q == DecideLim) ? '0 : decide_cnt_q + 8'd1;

  // Mode sequencing; a pellet pre-empts a coincident tick.
  always_comb begin
    mode_d       = mode_q;
    sec_cnt_d    = sec_cnt_q;
    round_d      = round_q;
    saved_mode_d = saved_mode_q;
    saved_cnt_d  = saved_cnt_q;
    if (pellet) begin
      if (mode_q != ModeFright) begin
        saved_mode_d = mode_q;
        saved_cnt_d  = sec_cnt_q;
        mode_d       = ModeFright;
      end
      sec_cnt_d = '0;
    end else if (sec_tick) begin
      unique case (mode_q)
        ModeScatter: begin
          if (cnt_inc >= ScatterLim) begin
            mode_d    = ModeChase;
            sec_cnt_d = '0;
            round_d   = round_q + 8'd1;
          end else begin
            sec_cnt_d = cnt_inc;
          end
        end
        ModeChase: begin
          if (cnt_inc >= ChaseLim) begin
            if (round_q < RoundLim) begin
              mode_d    = ModeScatter;
              sec_cnt_d = '0;
            end else begin
              sec_cnt_d = ChaseLim; // permanent CHASE; count saturates
            end
          end else begin
            sec_cnt_d = cnt_inc;
          end
        end
        ModeFright: begin
          if (cnt_inc >= FrightLim) begin
            mode_d    = saved_mode_q;
            sec_cnt_d = saved_cnt_q;
          end else begin
            sec_cnt_d = cnt_inc;
          end
        end
        default: begin
          mode_d    = ModeScatter;
          sec_cnt_d = '0;
        end
      endcase
    end
  end

  // Direction decision.
  logic [3:0]  open_v;
  logic        cur_valid, found, new_valid, decide, prim_x;
  logic [1:0]  cur_idx, rev_idx, x_tow, y_tow, pick, new_idx;
  logic [1:0]  cand [4];
  logic [9:0]  tgt_x, tgt_y;
  logic [10:0] dx, dy, adx, ady;

  always_comb begin
    open_v = {mapT == 5'd0, mapB == 5'd0, mapR == 5'd0, mapL == 5'd0};

    cur_valid = 1'b1;
    cur_idx   = DirL;
    case (dircode_q)
      8'h04:   cur_idx = DirL;
      8'h07:   cur_idx = DirR;
      8'h16:   cur_idx = DirD;
      8'h1A:   cur_idx = DirU;
      default: cur_valid = 1'b0;
    endcase
    rev_idx = cur_idx ^ 2'd1;

    tgt_x = (mode_q == ModeChase) ? pacX : ScatX;
    tgt_y = (mode_q == ModeChase) ? pacY : ScatY;
    dx    = {1'b0, tgt_x} - {1'b0, ghostX};
    dy    = {1'b0, tgt_y} - {1'b0, ghostY};
    adx   = dx[10] ? (~dx + 11'd1) : dx;
    ady   = dy[10] ? (~dy + 11'd1) : dy;
    // Zero delta counts as toward left / up.
    x_tow  = (!dx[10] && (dx != 11'd0)) ? DirR : DirL;
    y_tow  = (!dy[10] && (dy != 11'd0)) ? DirD : DirU;
    prim_x = (adx > ady);

    if (mode_q == ModeFright) begin
      for (int k = 0; k < 4; k++) begin
        cand[k] = lfsr_q[1:0] + 2'(k);
      end
    end else if (prim_x) begin
      cand[0] = x_tow;
      cand[1] = y_tow;
      cand[2] = y_tow ^ 2'd1;
      cand[3] = x_tow ^ 2'd1;
    end else begin
      cand[0] = y_tow;
      cand[1] = x_tow;
      cand[2] = x_tow ^ 2'd1;
      cand[3] = y_tow ^ 2'd1;
    end

    found = 1'b0;
    pick  = cand[0];
    for (int k = 0; k < 4; k++) begin
      if (!found && open_v[cand[k]] && !(cur_valid && (cand[k] == rev_idx))) begin
        found = 1'b1;
        pick  = cand[k];
      end
    end

    new_valid = found;
    new_idx   = pick;
    // Reverse is the fallback when nothing else qualifies, and is forced
    // on the first decision after a mode transition.
    if ((!found || mode_chg_q) && cur_valid && open_v[rev_idx]) begin
      new_valid = 1'b1;
      new_idx   = rev_idx;
    end

    decide = (decide_cnt_q == DecideLim) || !cur_valid ||
             (cur_valid && !open_v[cur_idx]) || mode_chg_q;

    dircode_d = dircode_q;
    if (decide) begin
      dircode_d = new_valid ? dir_code(new_idx) : 8'h00;
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      mode_q       <= ModeScatter;
      saved_mode_q <= ModeScatter;
      sec_cnt_q    <= '0;
      saved_cnt_q  <= '0;
      round_q      <= '0;
      decide_cnt_q <= '0;
      lfsr_q       <= LFSR_SEED;
      dircode_q    <= 8'h00;
      sec_prev_q   <= 1'b0;
      mode_chg_q   <= 1'b0;
      fright_q     <= 1'b0;
    end else if (restart) begin
      mode_q       <= ModeScatter;
      saved_mode_q <= ModeScatter;
      sec_cnt_q    <= '0;
      saved_cnt_q  <= '0;
      round_q      <= '0;
      decide_cnt_q <= '0;
      lfsr_q       <= LFSR_SEED;
      dircode_q    <= 8'h00;
      sec_prev_q   <= sec; // a level held through restart is not a new tick
      mode_chg_q   <= 1'b0;
      fright_q     <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      saved_mode_q <= saved_mode_d;
      sec_cnt_q    <= sec_cnt_d;
      saved_cnt_q  <= saved_cnt_d;
      round_q      <= round_d;
      decide_cnt_q <= decide_cnt_d;
      lfsr_q       <= lfsr_d;
      dircode_q    <= dircode_d;
      sec_prev_q   <= sec;
      mode_chg_q   <= (mode_d != mode_q);
      fright_q     <= (mode_d == ModeFright);
    end
  end

  assign dircode = dircode_q;
  assign mode    = mode_q;
  assign fright  = fright_q;

`ifdef GHOST_FRIGHT_BLINK_EN
  localparam logic [CntW-1:0] BlinkStart = (FRIGHT_SECS >= 2) ? CntW'(FRIGHT_SECS - 2) : '0;

  logic       blink_q, blink_win;
  logic [2:0] blink_cnt_q;

  assign blink_win = (mode_q == ModeFright) && (sec_cnt_q >= BlinkStart);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      blink_q     <= 1'b0;
      blink_cnt_q <= 3'd0;
    end else if (restart || !blink_win) begin
      blink_q     <= 1'b0;
      blink_cnt_q <= 3'd0;
    end else begin
      blink_cnt_q <= blink_cnt_q + 3'd1;
      if (blink_cnt_q == 3'd7) begin
        blink_q <= ~blink_q;
      end
    end
  end

  assign fright_blink = blink_q;
`endif

endmodule
